fifo_rr_write_arbiter: RTL and testbench
========================================

Name: fifo_rr_write_arbiter

Overview:
Shares the single write port of the team's BITS-wide FIFO among NUM_REQ requesters.
Uses round-robin arbitration with bounded bursts, so one requester can hold the port for at most BURST_MAX beats.
Sits directly in front of the FIFO: drives its write/data_in and obeys its overflow (full) flag.
Requesters use a valid/ready handshake; the FIFO read side is untouched.

Parameters:
BITS, 12, data word width (matches FIFO data width)
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width, must equal clog2(NUM_REQ)
BURST_MAX, 4, max beats accepted per grant (1..16)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester data-valid
req_data  input  NUM_REQ*BITS  requester i data at bits [i*BITS +: BITS]
req_ready  output  NUM_REQ  per-requester accept; transfer when valid & ready
fifo_write  output  1  to FIFO write, one per accepted beat
fifo_data_in  output  BITS  to FIFO data_in
fifo_overflow  input  1  FIFO full flag
grant_id  output  ID_W  index of currently/last granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Reset behaviour (rst_n async, active-low): state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins the first arbitration), beat_cnt=0, busy=0. req_ready=0 and fifo_write=0 while in reset.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the winner into grant_id and last_grant, clear beat_cnt, and go to GRANT.
  - Arbitration latency is 1 cycle; req_ready is 0 in IDLE.
- GRANT:
  - req_ready[grant_id] = ~fifo_overflow. All other req_ready bits are 0.
  - fifo_write = req_valid[grant_id] & ~fifo_overflow (combinational).
  - fifo_data_in = req_data slice of grant_id (combinational mux; value don't-care when fifo_write=0, mux output is acceptable).
  - Each accepted beat increments beat_cnt.
- Release (GRANT -> IDLE at the next edge) occurs on either condition:
  - (a) a beat is accepted with beat_cnt==BURST_MAX-1;
  - (b) req_valid[grant_id]==0 in any GRANT cycle, including while stalled.
  - A release always passes through IDLE, so there is one dead cycle between grants.
- Full stall: while fifo_overflow=1, no beat is accepted, beat_cnt is frozen and the grant is held (a stall alone never releases).
- Requester protocol: hold req_valid and data stable until accepted. Dropping valid before acceptance forfeits the grant (rule b).
- Fairness: a requester that releases becomes lowest priority. With all requesters valid, grant order is 0,1,2,3,0,… and each gets ≤BURST_MAX beats.
- Non-granted requesters are never accepted, whatever their valid.
- Throughput per grant: BURST_MAX beats in BURST_MAX cycles when not stalled, plus 1 arbitration cycle.
- Reset mid-burst: immediate return to reset values. Any partially sent burst is not resumed; the FIFO is reset by the same rst_n.
- beat_cnt width: enough for BURST_MAX-1. No wrap occurs because release happens at BURST_MAX-1.

Test Plan:
1. Reset, then req_valid=4'b0001 continuously with data 0x001..0x008, FIFO empty.
   -> Grant 0 one cycle after valid. fifo_write high for 4 cycles (0x001–0x004), 1 IDLE cycle, re-grant 0, then 0x005–0x008.
2. req_valid=4'b1111 held, each requester sending unique data.
   -> Grant order 0,1,2,3,0, 4 beats each. grant_id sequence is checked, and the FIFO content order matches.
3. During a grant to requester 2 after 2 beats, assert fifo_overflow for 3 cycles.
   -> req_ready[2]=0 and fifo_write=0 for 3 cycles, beat_cnt stays 2, grant kept. After deassert, exactly 2 more beats, then release.
4. Requester 1 granted, drops valid after 1 beat.
   -> Release next edge. With req_valid=4'b1010 otherwise, next grant is 3, then 1.
5. Assert rst_n=0 asynchronously mid-burst (grant 3, beat 2).
   -> busy, req_ready and fifo_write go 0 immediately. After release, the first grant goes to the lowest-index valid requester (0 if valid).
6. req_valid=4'b0100 while fifo_overflow=1 from reset.
   -> Grant 2 issued, busy=1, no writes. When overflow clears, 4 beats are accepted in 4 consecutive cycles.

Source files
------------

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several requesters.
// Bursts are bounded per grant, and a full FIFO stalls the burst without releasing it.
module fifo_rr_write_arbiter #(
    parameter int BITS      = 12,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    fifo_write,
    output logic [BITS-1:0]         fifo_data_in,
    input  logic                    fifo_overflow,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy
);

    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [CNT_W-1:0] beat_cnt;
    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  cand;
    logic             cur_valid;
    logic             accept;
    logic             last_beat;
    logic             release_now;

    assign busy        = (state == GRANT);
    assign cur_valid   = req_valid[grant_id];
    assign accept      = busy & cur_valid & ~fifo_overflow;
    assign last_beat   = (beat_cnt == LAST_BEAT);
    assign release_now = busy & (~cur_valid | (accept & last_beat));

    assign fifo_write   = accept;
    assign fifo_data_in = req_data[grant_id*BITS +: BITS];

    // Search upward from the requester after the last winner, wrapping around
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Only the granted requester may see ready, and only while the FIFO has room
    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[grant_id] = ~fifo_overflow;
        end
    end

    // Grant FSM: arbitrate in IDLE, count beats in GRANT, release back through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_INIT;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Bench for fifo_rr_write_arbiter: queue-fed requester models on the input side
// and an in-order scoreboard on the FIFO write side.
module tb_fifo_rr_write_arbiter;

    localparam int BITS = 12;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int BMAX = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*BITS-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_write;
    logic [BITS-1:0]      fifo_data_in;
    logic                 fifo_overflow;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    logic [BITS-1:0] src_q[NREQ][$];
    logic [BITS-1:0] exp_q[$];
    logic [NREQ-1:0] en;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_rr_write_arbiter #(
        .BITS(BITS), .NUM_REQ(NREQ), .ID_W(IDW), .BURST_MAX(BMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_write(fifo_write),
        .fifo_data_in(fifo_data_in),
        .fifo_overflow(fifo_overflow),
        .grant_id(grant_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: every FIFO write must match the next expected word
    always @(negedge clk) begin
        if (rst_n && fifo_write) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: write data=%h, none expected",
                         fifo_data_in);
            end else begin
                logic [BITS-1:0] e;
                e = exp_q.pop_front();
                if (fifo_data_in !== e)
                    $display("FAIL sb_data: got=%h exp=%h", fifo_data_in, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (src_q[i].size() > 0);
            req_data[i*BITS +: BITS] =
                (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc[i] && src_q[i].size() > 0)
                void'(src_q[i].pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset(input logic ovf);
        rst_n = 1'b0;
        fifo_overflow = ovf;
        en = '0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d words missing", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_overflow = 1'b0;
        en = 4'hf;
        for (int i = 0; i < NREQ; i++) src_q[i].push_back(12'h0aa);
        drive();
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got=%b exp=0", busy);
        else n_pass++;
        n_checks++;
        if (req_ready !== 4'h0)
            $display("FAIL rst_ready: got=%b exp=0000", req_ready);
        else n_pass++;
        n_checks++;
        if (fifo_write !== 1'b0)
            $display("FAIL rst_write: got=%b exp=0", fifo_write);
        else n_pass++;
        n_checks++;
        if (grant_id !== 2'd0)
            $display("FAIL rst_grant: got=%0d exp=0", grant_id);
        else n_pass++;
    endtask

    task automatic test_single();
        bit exp_w[11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            src_q[0].push_back(BITS'(k));
            exp_q.push_back(BITS'(k));
        end
        en = 4'b0001;
        drive();
        #1;
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (fifo_write !== exp_w[k] ||
                (exp_w[k] && grant_id !== 2'd0))
                $display("FAIL single_step%0d: write=%b grant=%0d exp write=%b grant=0",
                         k, fifo_write, grant_id, exp_w[k]);
            else
                n_pass++;
            if (k < 10) tick();
        end
        check_drained("single");
    endtask

    task automatic test_all_valid();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        do_reset(1'b0);
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++)
                src_q[i].push_back({4'(i + 1), 8'(k)});
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back({4'(exp_g[g] + 1), 8'(k + ((g == 4) ? 4 : 0))});
        en = 4'b1111;
        drive();
        for (int g = 0; g < 5; g++) begin
            tick();
            n_checks++;
            if (busy !== 1'b1 || grant_id !== IDW'(exp_g[g]))
                $display("FAIL rr_grant%0d: busy=%b grant=%0d exp busy=1 grant=%0d",
                         g, busy, grant_id, exp_g[g]);
            else
                n_pass++;
            repeat (4) tick();
            n_checks++;
            if (busy !== 1'b0)
                $display("FAIL rr_dead%0d: busy=%b exp=0", g, busy);
            else
                n_pass++;
        end
        check_drained("rr");
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) src_q[2].push_back(12'h200 + BITS'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(12'h200 + BITS'(k));
        en = 4'b0100;
        drive();
        repeat (3) tick();
        fifo_overflow = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (req_ready[2] !== 1'b0 || fifo_write !== 1'b0 ||
                busy !== 1'b1 || grant_id !== 2'd2)
                $display("FAIL stall_c%0d: ready=%b write=%b busy=%b grant=%0d exp 0 0 1 2",
                         c, req_ready[2], fifo_write, busy, grant_id);
            else
                n_pass++;
            tick();
        end
        fifo_overflow = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (fifo_write !== 1'b1 || grant_id !== 2'd2)
                $display("FAIL stall_resume%0d: write=%b grant=%0d exp 1 2",
                         c, fifo_write, grant_id);
            else
                n_pass++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || fifo_write !== 1'b0)
            $display("FAIL stall_release: busy=%b write=%b exp 0 0",
                     busy, fifo_write);
        else
            n_pass++;
        en = 4'b0000;
        drive();
        tick();
        check_drained("stall");
    endtask

    task automatic test_drop();
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) src_q[1].push_back(12'h110 + BITS'(k));
        for (int k = 1; k <= 4; k++) src_q[3].push_back(12'h300 + BITS'(k));
        exp_q.push_back(12'h111);
        for (int k = 1; k <= 4; k++) exp_q.push_back(12'h300 + BITS'(k));
        for (int k = 2; k <= 5; k++) exp_q.push_back(12'h110 + BITS'(k));
        en = 4'b1010;
        drive();
        tick();
        n_checks++;
        if (grant_id !== 2'd1 || busy !== 1'b1)
            $display("FAIL drop_first: grant=%0d busy=%b exp 1 1", grant_id, busy);
        else
            n_pass++;
        tick();
        en[1] = 1'b0;
        drive();
        #1;
        n_checks++;
        if (fifo_write !== 1'b0)
            $display("FAIL drop_nowrite: write=%b exp 0", fifo_write);
        else
            n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL drop_release: busy=%b exp 0", busy);
        else
            n_pass++;
        en[1] = 1'b1;
        drive();
        tick();
        n_checks++;
        if (grant_id !== 2'd3 || busy !== 1'b1)
            $display("FAIL drop_next3: grant=%0d busy=%b exp 3 1", grant_id, busy);
        else
            n_pass++;
        repeat (4) tick();
        tick();
        n_checks++;
        if (grant_id !== 2'd1 || busy !== 1'b1)
            $display("FAIL drop_next1: grant=%0d busy=%b exp 1 1", grant_id, busy);
        else
            n_pass++;
        repeat (4) tick();
        check_drained("drop");
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) src_q[3].push_back(12'h300 + BITS'(k));
        exp_q.push_back(12'h301);
        exp_q.push_back(12'h302);
        en = 4'b1000;
        drive();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 4'h0 || fifo_write !== 1'b0)
            $display("FAIL arst_outputs: busy=%b ready=%b write=%b exp 0 0000 0",
                     busy, req_ready, fifo_write);
        else
            n_pass++;
        check_drained("arst_partial");
        for (int k = 1; k <= 4; k++) begin
            src_q[0].push_back(BITS'(k));
            exp_q.push_back(BITS'(k));
        end
        en = 4'b1001;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tick();
        n_checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1)
            $display("FAIL arst_regrant: grant=%0d busy=%b exp 0 1", grant_id, busy);
        else
            n_pass++;
        repeat (4) tick();
        en = 4'b0000;
        drive();
        tick();
        check_drained("arst");
    endtask

    task automatic test_full_from_reset();
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            src_q[2].push_back(12'h2a0 + BITS'(k));
            exp_q.push_back(12'h2a0 + BITS'(k));
        end
        en = 4'b0100;
        drive();
        tick();
        n_checks++;
        if (grant_id !== 2'd2 || busy !== 1'b1 || fifo_write !== 1'b0)
            $display("FAIL full_grant: grant=%0d busy=%b write=%b exp 2 1 0",
                     grant_id, busy, fifo_write);
        else
            n_pass++;
        repeat (2) tick();
        n_checks++;
        if (fifo_write !== 1'b0 || busy !== 1'b1)
            $display("FAIL full_hold: write=%b busy=%b exp 0 1", fifo_write, busy);
        else
            n_pass++;
        fifo_overflow = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (fifo_write !== 1'b1)
                $display("FAIL full_burst%0d: write=%b exp 1", c, fifo_write);
            else
                n_pass++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL full_release: busy=%b exp 0", busy);
        else
            n_pass++;
        check_drained("full");
    endtask

    initial begin
        rst_n = 1'b0;
        fifo_overflow = 1'b0;
        en = '0;
        req_valid = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_stall();
        test_drop();
        test_async_reset();
        test_full_from_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
